// File: rtl/conv_ctrl.sv
// Frame/line sequencer for the 3x3 grey convolution path: tracks pixel position,
// latches the filter select per frame and aligns valid/border with the filter result.
module conv_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic        iSW,
  output logic        oSEL,
  output logic        oDVAL,
  output logic        oBORDER,
  output logic [10:0] oCOL,
  output logic [10:0] oROW,
  output logic [1:0]  oSTATE,
  output logic [7:0]  oFRAME_CNT,
  output logic        oERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [10:0] COL_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] ROW_LAST = 11'(IMG_H - 1);

  state_t state, stateNext;
  logic   accept, errSet, selLoad, posClr, frameEnd;
  logic   colLast, rowLast, pixBorder;
  logic   swMeta, swSync;
  logic [PIPE_LAT:0] vldPipe, bdrPipe;

  assign colLast   = (oCOL == COL_LAST);
  assign rowLast   = (oROW == ROW_LAST);
  assign pixBorder = !((oROW >= 11'd2) && (oCOL >= 11'd2));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      swMeta <= 1'b0;
      swSync <= 1'b0;
    end else begin
      swMeta <= iSW;
      swSync <= swMeta;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // A cycle that drops iFVAL inside the frame is an abort, so its pixel is not taken.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    errSet    = 1'b0;
    selLoad   = 1'b0;
    posClr    = 1'b0;
    frameEnd  = 1'b0;
    case (state)
      IDLE: begin
        if (iFVAL) begin
          stateNext = FILL;
          selLoad   = 1'b1;
        end
      end
      FILL: begin
        if (!iFVAL) begin
          stateNext = IDLE;
          errSet    = 1'b1;
          posClr    = 1'b1;
        end else if (iDVAL) begin
          accept = 1'b1;
          if (colLast && oROW == 11'd1) stateNext = RUN;
        end
      end
      RUN: begin
        if (!iFVAL) begin
          stateNext = IDLE;
          errSet    = 1'b1;
          posClr    = 1'b1;
        end else if (iDVAL) begin
          accept = 1'b1;
          if (colLast && rowLast) begin
            stateNext = DONE;
            frameEnd  = 1'b1;
          end
        end
      end
      DONE: begin
        if (iDVAL) errSet = 1'b1;
        if (!iFVAL) begin
          stateNext = IDLE;
          posClr    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST || posClr) begin
      oCOL <= '0;
      oROW <= '0;
    end else if (accept) begin
      if (colLast) begin
        oCOL <= '0;
        oROW <= oROW + 11'd1;
      end else begin
        oCOL <= oCOL + 11'd1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSEL       <= 1'b0;
      oERR       <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      if (selLoad)  oSEL       <= swSync;
      if (errSet)   oERR       <= 1'b1;
      if (frameEnd) oFRAME_CNT <= oFRAME_CNT + 8'd1;
    end
  end

  // Border bit is pushed pre-qualified so it can never be high without valid.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vldPipe <= '0;
      bdrPipe <= '0;
    end else begin
      vldPipe <= {vldPipe[PIPE_LAT-1:0], accept};
      bdrPipe <= {bdrPipe[PIPE_LAT-1:0], accept & pixBorder};
    end
  end

  assign oDVAL   = vldPipe[PIPE_LAT];
  assign oBORDER = bdrPipe[PIPE_LAT];
  assign oSTATE  = state;

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl on a 4x3 frame; a scoreboard of expected
// output cycles/border flags is checked against oDVAL/oBORDER every cycle.
module tb_conv_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int LAT = 2;

  logic        iCLK = 1'b0;
  logic        iRST, iFVAL, iDVAL, iSW;
  logic        oSEL, oDVAL, oBORDER, oERR;
  logic [10:0] oCOL, oROW;
  logic [1:0]  oSTATE;
  logic [7:0]  oFRAME_CNT;

  conv_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iSW(iSW),
    .oSEL(oSEL), .oDVAL(oDVAL), .oBORDER(oBORDER), .oCOL(oCOL), .oROW(oROW),
    .oSTATE(oSTATE), .oFRAME_CNT(oFRAME_CNT), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int   cyc;
    logic bdr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge iCLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic bdrOf(input int n);
    int r, c;
    r = n / W;
    c = n % W;
    return !(r >= 2 && c >= 2);
  endfunction

  // Called while iDVAL=1 is being driven into a cycle that will accept it.
  task automatic push(input int n);
    exp_t e;
    e.cyc = cyc + 1 + LAT;
    e.bdr = bdrOf(n);
    q.push_back(e);
  endtask

  always @(negedge iCLK) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("dval_missed", 32'(q[0].cyc), 32'(cyc));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("dval_pulse", 32'(oDVAL), 32'd1);
      chk("border", 32'(oBORDER), 32'(q[0].bdr));
      void'(q.pop_front());
    end else begin
      chk("dval_idle", 32'(oDVAL), 32'd0);
      chk("border_idle", 32'(oBORDER), 32'd0);
    end
  end

  task automatic chkAllZero(input string tag);
    chk({tag, "_state"}, 32'(oSTATE), 32'd0);
    chk({tag, "_sel"}, 32'(oSEL), 32'd0);
    chk({tag, "_col"}, 32'(oCOL), 32'd0);
    chk({tag, "_row"}, 32'(oROW), 32'd0);
    chk({tag, "_fcnt"}, 32'(oFRAME_CNT), 32'd0);
    chk({tag, "_err"}, 32'(oERR), 32'd0);
    chk({tag, "_dval"}, 32'(oDVAL), 32'd0);
    chk({tag, "_bdr"}, 32'(oBORDER), 32'd0);
  endtask

  initial begin
    int acc;
    // reset held with frame and data active
    iRST = 1'b1; iFVAL = 1'b1; iDVAL = 1'b1; iSW = 1'b0;
    tick(); chkAllZero("rst1");
    tick(); chkAllZero("rst2");
    iRST = 1'b0;
    tick();
    chk("fill_after_rst", 32'(oSTATE), 32'd1);
    chk("idle_pix_ignored", 32'(oCOL), 32'd0);
    iDVAL = 1'b0; iFVAL = 1'b0;
    tick();
    chk("abort_err", 32'(oERR), 32'd1);
    chk("abort_state", 32'(oSTATE), 32'd0);
    iRST = 1'b1; iSW = 1'b1;
    tick();
    chk("err_cleared", 32'(oERR), 32'd0);

    // full frame, select=1
    iRST = 1'b0;
    tick(); tick(); tick();
    iFVAL = 1'b1;
    tick();
    chk("b_fill", 32'(oSTATE), 32'd1);
    chk("b_sel", 32'(oSEL), 32'd1);
    for (int n = 0; n < W * H; n++) begin
      iDVAL = 1'b1; push(n);
      tick();
      if (n == 0) begin
        chk("b_col1", 32'(oCOL), 32'd1);
        chk("b_row0", 32'(oROW), 32'd0);
      end
      if (n == 3) begin
        chk("b_wrap_col", 32'(oCOL), 32'd0);
        chk("b_wrap_row", 32'(oROW), 32'd1);
      end
      if (n == 6) chk("b_still_fill", 32'(oSTATE), 32'd1);
      if (n == 7) chk("b_run", 32'(oSTATE), 32'd2);
      if (n == 10) chk("b_fcnt_pre", 32'(oFRAME_CNT), 32'd0);
    end
    chk("b_done", 32'(oSTATE), 32'd3);
    chk("b_fcnt", 32'(oFRAME_CNT), 32'd1);
    iDVAL = 1'b0;
    repeat (4) tick();
    iFVAL = 1'b0;
    tick();
    chk("b_idle", 32'(oSTATE), 32'd0);
    chk("b_col_clr", 32'(oCOL), 32'd0);
    chk("b_row_clr", 32'(oROW), 32'd0);
    chk("b_no_err", 32'(oERR), 32'd0);

    // select switch toggled mid-frame
    iSW = 1'b0;
    repeat (3) tick();
    iFVAL = 1'b1;
    tick();
    chk("c_sel0", 32'(oSEL), 32'd0);
    for (int n = 0; n < W * H; n++) begin
      if (n == 8) iSW = 1'b1;
      iDVAL = 1'b1; push(n);
      tick();
    end
    chk("c_sel_held", 32'(oSEL), 32'd0);
    chk("c_done", 32'(oSTATE), 32'd3);
    chk("c_fcnt", 32'(oFRAME_CNT), 32'd2);
    iDVAL = 1'b0;
    repeat (3) tick();
    iFVAL = 1'b0;
    tick();
    chk("c_sel_idle", 32'(oSEL), 32'd0);
    iFVAL = 1'b1;
    tick();
    chk("c_sel_next", 32'(oSEL), 32'd1);

    // abort after 5 pixels
    for (int n = 0; n < 5; n++) begin
      iDVAL = 1'b1; push(n);
      tick();
    end
    iDVAL = 1'b0; iFVAL = 1'b0;
    tick();
    chk("d_err", 32'(oERR), 32'd1);
    chk("d_state", 32'(oSTATE), 32'd0);
    chk("d_col", 32'(oCOL), 32'd0);
    chk("d_row", 32'(oROW), 32'd0);
    chk("d_fcnt", 32'(oFRAME_CNT), 32'd2);
    repeat (4) tick();

    // alternating valid
    iFVAL = 1'b1;
    tick();
    acc = 0;
    for (int i = 0; i < 2 * W * H; i++) begin
      iDVAL = (i % 2 == 0);
      if (iDVAL) push(acc);
      tick();
      if (i % 2 == 0) begin
        acc++;
        if (acc == 8) chk("e_run", 32'(oSTATE), 32'd2);
      end
    end
    chk("e_done", 32'(oSTATE), 32'd3);
    chk("e_fcnt", 32'(oFRAME_CNT), 32'd3);
    iDVAL = 1'b0;
    repeat (3) tick();
    iFVAL = 1'b0;
    tick();
    chk("e_idle", 32'(oSTATE), 32'd0);

    // reset during RUN with two pixels in flight
    iFVAL = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) begin
      iDVAL = 1'b1; push(n);
      tick();
    end
    chk("f_run", 32'(oSTATE), 32'd2);
    iRST = 1'b1; iDVAL = 1'b0;
    while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
    tick();
    chkAllZero("f_rst");
    iRST = 1'b0;
    tick();
    chk("f_fill", 32'(oSTATE), 32'd1);
    chk("f_sel_sync", 32'(oSEL), 32'd0);
    for (int n = 0; n < W * H; n++) begin
      iDVAL = 1'b1; push(n);
      tick();
    end
    chk("f_done", 32'(oSTATE), 32'd3);
    chk("f_fcnt", 32'(oFRAME_CNT), 32'd1);
    chk("f_no_err", 32'(oERR), 32'd0);
    iDVAL = 1'b1;
    tick();
    chk("f_done_err", 32'(oERR), 32'd1);
    chk("f_done_stay", 32'(oSTATE), 32'd3);
    chk("f_done_col", 32'(oCOL), 32'd0);
    iDVAL = 1'b0; iFVAL = 1'b0;
    tick();
    chk("f_idle", 32'(oSTATE), 32'd0);
    chk("f_fcnt_keep", 32'(oFRAME_CNT), 32'd1);
    repeat (6) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
